serial_buff_mc: RTL

Parametrised multi-channel successor to serial_buff. It deserialises NCH parallel serial lines into NDATA-bit words, sampling one bit per channel on each cntin strobe from the shared counter. Each channel has a selectable bit order. Completed frames go to an output register with a valid/ready handshake and sticky overflow reporting. It sits between the serial front end and the frame consumer.

---
 rtl/serial_buff_mc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_buff_mc.sv
// Multi-channel serial-to-parallel frame buffer with per-channel bit order and valid/ready output.
// Optional trailing even-parity bit per channel is enabled with the SERIAL_BUFF_PARITY_EN macro.
module serial_buff_mc #(
  parameter int NDATA = 128,
  parameter int NCH   = 1,
  parameter int CNTW  = $clog2(NDATA + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cntin,
  input  logic [NCH-1:0]        din,
  input  logic                  msb_first,
  output logic [NCH*NDATA-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       bitcnt,
  output logic                  ovf,
  output logic [NCH-1:0]        perr
);

`ifdef SERIAL_BUFF_PARITY_EN
  localparam int FRAME_LEN = NDATA + 1;
`else
  localparam int FRAME_LEN = NDATA;
`endif
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAME_LEN - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]           state;
  logic [NCH*NDATA-1:0] sh;
  logic [NCH*NDATA-1:0] sh_next;
  logic [NCH*NDATA-1:0] frame_word;
  logic                 order_q;
  logic                 order_eff;
  logic                 strobe;
  logic                 complete;
  logic                 load;

  // The state is fully described by the bit counter, so it is derived rather than stored.
  assign state     = (bitcnt == '0) ? S_IDLE : S_SHIFT;
  assign busy      = (state == S_SHIFT);
  assign order_eff = (state == S_IDLE) ? msb_first : order_q;
  assign strobe    = ena && cntin;
  assign complete  = strobe && (bitcnt == LAST_CNT);
  assign load      = complete && (!dout_valid || dout_ready);

  always_comb begin
    sh_next = sh;
    for (int c = 0; c < NCH; c++) begin
      if (order_eff)
        sh_next[c*NDATA +: NDATA] = {sh[c*NDATA +: NDATA-1], din[c]};
      else
        sh_next[c*NDATA +: NDATA] = {din[c], sh[c*NDATA+1 +: NDATA-1]};
    end
  end

`ifdef SERIAL_BUFF_PARITY_EN
  // The final strobe carries parity only, so the word is already complete in the shift register.
  logic [NCH-1:0] par_next;

  assign frame_word = sh;

  always_comb begin
    par_next = '0;
    for (int c = 0; c < NCH; c++)
      par_next[c] = (^sh[c*NDATA +: NDATA]) ^ din[c];
  end

  always_ff @(posedge clk) begin
    if (rst)
      perr <= '0;
    else if (load)
      perr <= par_next;
  end
`else
  assign frame_word = sh_next;
  assign perr       = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sh         <= '0;
      bitcnt     <= '0;
      order_q    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (!ena) begin
        sh     <= '0;
        bitcnt <= '0;
      end else if (cntin) begin
        if (state == S_IDLE)
          order_q <= msb_first;
        if (complete) begin
          sh     <= '0;
          bitcnt <= '0;
        end else begin
          sh     <= sh_next;
          bitcnt <= bitcnt + CNTW'(1);
        end
      end

      // A frame completing against a full, unaccepted output register is dropped.
      if (load) begin
        dout       <= frame_word;
        dout_valid <= 1'b1;
      end else if (complete) begin
        ovf <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
